// File: rtl/ascon_pkg.sv
// Shared definitions for the round-constant sequencer: the default schedule
// length, the controller state type and the constant formula.
package ascon_pkg;

    localparam int MAX_ROUNDS_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Constant for schedule index idx: high nibble counts down while the low nibble counts up
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

endpackage

// File: rtl/round_const_rom.sv
// Combinational lookup from the 4-bit schedule index to the 8-bit round constant.
module round_const_rom
    import ascon_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] rc
);

    // Constant table evaluated from the shared formula
    always_comb begin
        rc = round_const(idx);
    end

endmodule

// File: rtl/round_const_seq.sv
// Round-constant sequencer: walks the tail of the constant schedule for a
// requested round count and XORs each constant into the x2 lane.
module round_const_seq
    import ascon_pkg::*;
#(
    parameter int LANE_W     = 64,
    parameter int MAX_ROUNDS = MAX_ROUNDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        rounds,
    input  logic              hold,
    input  logic [LANE_W-1:0] x2_in,
    output logic [LANE_W-1:0] x2_out,
    output logic [7:0]        const_out,
    output logic [3:0]        round_idx,
    output logic              out_valid,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

    state_t     state_r;
    logic [3:0] rounds_r;
    logic [3:0] base_r;
    logic [3:0] i_r;
    logic [3:0] const_idx_s;
    logic [7:0] rc_s;
    logic       rounds_ok_s;
    logic       last_round_s;

    // Shorter permutations use the tail of the schedule, so the index is offset by base
    always_comb begin
        const_idx_s  = base_r + i_r;
        rounds_ok_s  = (rounds != 4'd0) && ({1'b0, rounds} <= MAX_R);
        last_round_s = (i_r == (rounds_r - 4'd1));
    end

    round_const_rom u_rom (
        .idx (const_idx_s),
        .rc  (rc_s)
    );

    // Controller and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rounds_r  <= 4'd0;
            base_r    <= 4'd0;
            i_r       <= 4'd0;
            x2_out    <= '0;
            const_out <= 8'd0;
            round_idx <= 4'd0;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (rounds_ok_s) begin
                            rounds_r <= rounds;
                            i_r      <= 4'd0;
                            base_r   <= 4'(MAX_R - {1'b0, rounds});
                            busy     <= 1'b1;
                            state_r  <= ST_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A stall leaves the data outputs and the round counter untouched
                    if (!hold) begin
                        x2_out    <= x2_in ^ LANE_W'(rc_s);
                        const_out <= rc_s;
                        round_idx <= i_r;
                        out_valid <= 1'b1;
                        i_r       <= i_r + 4'd1;
                        if (last_round_s) begin
                            last    <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_const_seq.sv
// Directed bench for round_const_seq with hand-computed constant tables.
module tb_round_const_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rounds;
    logic        hold;
    logic [63:0] x2_in;
    logic [63:0] x2_out;
    logic [7:0]  const_out;
    logic [3:0]  round_idx;
    logic        out_valid;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec    = 0;
    int n_miscmp = 0;

    // Full 12-round schedule; shorter runs start part-way in
    logic [7:0] rc_tbl [0:11] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    always #5 clk = ~clk;

    round_const_seq #(.LANE_W(64), .MAX_ROUNDS(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rounds    (rounds),
        .hold      (hold),
        .x2_in     (x2_in),
        .x2_out    (x2_out),
        .const_out (const_out),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_x2"},    x2_out, 64'd0);
        check_val({tag, "_const"}, {56'd0, const_out}, 64'd0);
        check_val({tag, "_idx"},   {60'd0, round_idx}, 64'd0);
        check_val({tag, "_flags"}, {59'd0, out_valid, last, busy, done, err}, 64'd0);
    endtask

    // One permutation; hmask bit n stalls the n-th RUN cycle, poke pulses start in RUN and DONE
    task automatic run_perm(input logic [3:0] r, input logic [63:0] x, input logic [15:0] hmask,
                            input int first, input bit poke);
        int         k;
        int         done_cnt;
        bit         err_seen;
        bit         saw_last;
        bit         last_prev;
        bit         h;
        logic [7:0] prev_c;
        logic [63:0] prev_x;
        k = 0; done_cnt = 0; err_seen = 1'b0; saw_last = 1'b0; last_prev = 1'b0;
        x2_in = x; rounds = r; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_run", {63'd0, busy}, 64'd1);
        for (int cyc = 0; cyc < 40 && done_cnt == 0; cyc++) begin
            h = (cyc < 16) ? hmask[cyc] : 1'b0;
            hold = h;
            start = poke && (cyc == 2 || saw_last);
            if (start) rounds = 4'd0;
            prev_c = const_out;
            prev_x = x2_out;
            tick();
            err_seen |= err;
            if (cyc == 0 && !h)
                check_val("first_latency", {63'd0, out_valid}, 64'd1);
            if (done) begin
                done_cnt++;
                check_val("done_after_last", {63'd0, last_prev}, 64'd1);
                check_val("done_no_valid", {63'd0, out_valid}, 64'd0);
            end else if (h && !saw_last) begin
                check_val("stall_valid", {63'd0, out_valid}, 64'd0);
                check_val("stall_const", {56'd0, const_out}, {56'd0, prev_c});
                check_val("stall_x2", x2_out, prev_x);
            end else if (out_valid) begin
                if (first + k < 12) begin
                    check_val("const", {56'd0, const_out}, {56'd0, rc_tbl[first + k]});
                    check_val("x2", x2_out, x ^ {56'd0, rc_tbl[first + k]});
                    check_val("round_idx", {60'd0, round_idx}, 64'(k));
                    check_val("last", {63'd0, last}, {63'd0, (k == int'(r) - 1)});
                end else begin
                    check_val("extra_valid", {63'd0, out_valid}, 64'd0);
                end
                if (last) saw_last = 1'b1;
                k++;
            end
            last_prev = last;
        end
        start = 1'b0; hold = 1'b0; rounds = r;
        check_val("n_valid", 64'(k), 64'(r));
        check_val("done_cnt", 64'(done_cnt), 64'd1);
        check_val("err_quiet", {63'd0, err_seen}, 64'd0);
        tick();
        check_val("done_single", {63'd0, done}, 64'd0);
        check_val("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic bad_request(input logic [3:0] r);
        rounds = r; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("err_pulse", {63'd0, err}, 64'd1);
        check_val("err_busy", {63'd0, busy}, 64'd0);
        check_val("err_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check_val("err_one_cycle", {63'd0, err}, 64'd0);
        check_val("err_still_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        bit found;
        int done_seen;
        rst = 1'b1; start = 1'b0; hold = 1'b0; rounds = 4'd0; x2_in = 64'd0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        hold = 1'b1;
        tick();
        check_val("hold_idle", {63'd0, busy}, 64'd0);
        hold = 1'b0;

        run_perm(4'd12, 64'd0, 16'h0000, 0, 1'b0);
        run_perm(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 6, 1'b0);
        run_perm(4'd8, 64'h0123_4567_89AB_CDEF, 16'h000C, 4, 1'b0);

        bad_request(4'd0);
        bad_request(4'd13);

        // Abort a 12-round permutation part-way through
        found = 1'b0;
        rounds = 4'd12; x2_in = 64'h5555_AAAA_5555_AAAA; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (out_valid && round_idx == 4'd3) found = 1'b1;
        end
        check_val("abort_reached_idx3", {63'd0, found}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("abort");
        done_seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (done) done_seen++;
        end
        check_val("abort_no_done", 64'(done_seen), 64'd0);
        run_perm(4'd6, 64'd0, 16'h0000, 6, 1'b0);

        run_perm(4'd12, 64'hDEAD_BEEF_0BAD_F00D, 16'h0000, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
